muldiv_sequencer: RTL and testbench

//  Multi-cycle controller for the M-extension ops the decoder emits as alufunc:
//  ALU_MULT, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, in 64-bit and word (ALUW) forms.
//  It sits beside the execute-stage ALU and sequences an iterative shift-add multiplier
//  and a restoring divider. It holds the pipeline through busy until the result is ready.

---
 rtl/pipes_pkg.sv | 41 ++++
 rtl/muldiv_signfix.sv | 39 +++
 rtl/muldiv_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipes_pkg.sv
// Shared pipeline types for the execute-stage muldiv controller.
//   alufunc_t       : ALU function code emitted by the decoder
//   muldiv_state_t  : muldiv sequencer FSM states
//   MULDIV_XLEN/WLEN: full and word operand widths
//   is_muldiv()     : true for the functions handled by the muldiv sequencer
package pipes_pkg;

  localparam int unsigned MULDIV_XLEN = 64;
  localparam int unsigned MULDIV_WLEN = 32;

  typedef enum logic [4:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor,
    AluSll,
    AluSrl,
    AluSra,
    AluSlt,
    AluSltu,
    AluMult,
    AluDiv,
    AluDivu,
    AluRem,
    AluRemu
  } alufunc_t;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFixup,
    StDone
  } muldiv_state_t;

  function automatic logic is_muldiv(alufunc_t f);
    return f inside {AluMult, AluDiv, AluDivu, AluRem, AluRemu};
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Two-lane combinational sign fixer for the muldiv sequencer.
// Each lane optionally negates its value, then for word ops keeps the low WLEN bits and
// either sign-extends (wsext_i=1) or zero-extends (wsext_i=0) them to XLEN.
//   a_i/b_i     : lane inputs
//   word_i      : word (ALUW) form
//   neg_a_i/b_i : negate the lane before extension
//   wsext_i     : word extension kind
//   a_o/b_o     : lane outputs
module muldiv_signfix
  import pipes_pkg::*;
#(
  parameter int unsigned XLEN = MULDIV_XLEN,
  parameter int unsigned WLEN = MULDIV_WLEN
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            word_i,
  input  logic            neg_a_i,
  input  logic            neg_b_i,
  input  logic            wsext_i,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o
);

  // Negate first, extend second: -(2^31) as a word quotient must come out sign-extended.
  function automatic logic [XLEN-1:0] fix_lane(logic [XLEN-1:0] v, logic neg, logic word,
                                               logic wsext);
    logic [XLEN-1:0] t;
    t = neg ? (~v + XLEN'(1)) : v;
    if (word) begin
      t = {{(XLEN-WLEN){wsext & t[WLEN-1]}}, t[WLEN-1:0]};
    end
    return t;
  endfunction

  assign a_o = fix_lane(a_i, neg_a_i, word_i, wsext_i);
  assign b_o = fix_lane(b_i, neg_b_i, word_i, wsext_i);

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle M-extension controller beside the execute-stage ALU: iterative shift-add
// multiplier (low XLEN bits) and restoring divider, one step per cycle.
//   clk_i, reset_i   : clock, asynchronous active-high reset
//   req_valid_i      : op presented; req_ready_o high only in idle
//   func_i, is_word_i: function code and word form
//   src_a_i, src_b_i : rs1 / rs2 values
//   flush_i          : kill any in-flight op, no response
//   busy_o           : pipeline stall request
//   resp_valid_o     : one-cycle result pulse; result_o holds until the next pulse
module muldiv_sequencer
  import pipes_pkg::*;
#(
  parameter int unsigned XLEN = MULDIV_XLEN,
  parameter int unsigned WLEN = MULDIV_WLEN
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  alufunc_t        func_i,
  input  logic            is_word_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] XMin = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [WLEN-1:0] WMin = {1'b1, {(WLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] opa_q, opa_d;  // multiplier / dividend, becomes quotient
  logic [XLEN-1:0] opb_q, opb_d;  // multiplicand / divisor
  logic [XLEN-1:0] acc_q, acc_d;  // product / partial remainder
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            word_q, word_d, signed_q, signed_d, rem_q, rem_d, mul_q, mul_d;
  logic            sa_q, sa_d, sb_q, sb_d;

  // Request decode
  logic            accept, start;
  logic            op_mul, op_div, op_signed, op_rem, sa, sb;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] prep_a, prep_b, a_ext, special_res;

  assign accept    = req_valid_i & req_ready_o;
  assign start     = accept & ~flush_i;
  assign op_mul    = (func_i == AluMult);
  assign op_div    = is_muldiv(func_i) & ~op_mul;
  assign op_signed = func_i inside {AluDiv, AluRem};
  assign op_rem    = func_i inside {AluRem, AluRemu};
  assign sa        = op_signed & (is_word_i ? src_a_i[WLEN-1] : src_a_i[XLEN-1]);
  assign sb        = op_signed & (is_word_i ? src_b_i[WLEN-1] : src_b_i[XLEN-1]);

  // Prep yields |a|, |b| (zero-extended for word ops) for the unsigned divider core.
  muldiv_signfix #(
    .XLEN(XLEN),
    .WLEN(WLEN)
  ) u_prep (
    .a_i    (src_a_i),
    .b_i    (src_b_i),
    .word_i (is_word_i),
    .neg_a_i(sa),
    .neg_b_i(sb),
    .wsext_i(1'b0),
    .a_o    (prep_a),
    .b_o    (prep_b)
  );

  assign b_zero = (prep_b == '0);
  assign ovf    = op_signed & (is_word_i ?
                  (src_a_i[WLEN-1:0] == WMin) && (src_b_i[WLEN-1:0] == '1) :
                  (src_a_i == XMin) && (src_b_i == '1));
  assign special = op_div & (b_zero | ovf);
  assign a_ext   = is_word_i ? {{(XLEN-WLEN){src_a_i[WLEN-1]}}, src_a_i[WLEN-1:0]} : src_a_i;
  assign special_res = b_zero ? (op_rem ? a_ext : '1) : (op_rem ? '0 : a_ext);

  // Result fixup
  logic [XLEN-1:0] fix_a, fix_b;

  muldiv_signfix #(
    .XLEN(XLEN),
    .WLEN(WLEN)
  ) u_fix (
    .a_i    (mul_q ? acc_q : opa_q),
    .b_i    (acc_q),
    .word_i (word_q),
    .neg_a_i(signed_q & (sa_q ^ sb_q)),
    .neg_b_i(signed_q & sa_q),
    .wsext_i(1'b1),
    .a_o    (fix_a),
    .b_o    (fix_b)
  );

  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  logic [XLEN:0] div_tmp, div_diff;
  logic          div_fits;

  assign div_tmp  = {acc_q, opa_q[XLEN-1]};
  assign div_diff = div_tmp - {1'b0, opb_q};
  assign div_fits = ~div_diff[XLEN];

  // FSM: state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (op_mul)                 state_d = StMul;
          else if (op_div && !special) state_d = StDiv;
          else                        state_d = StDone;
        end
      end
      StMul, StDiv: if (cnt_q == '0) state_d = StFixup;
      StFixup:      state_d = StDone;
      StDone:       state_d = StIdle;
      default:      state_d = StIdle;
    endcase
    if (flush_i) state_d = StIdle;
  end

  // FSM: outputs
  always_comb begin
    req_ready_o  = (state_q == StIdle);
    busy_o       = accept | ((state_q != StIdle) && (state_q != StDone));
    resp_valid_o = (state_q == StDone) & ~flush_i;
    result_o     = resp_valid_o ? pend_q : result_q;
  end

  // Datapath next state
  always_comb begin
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    pend_d   = pend_q;
    result_d = result_q;
    word_d   = word_q;
    signed_d = signed_q;
    rem_d    = rem_q;
    mul_d    = mul_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d    = is_word_i ? CntW'(WLEN - 1) : CntW'(XLEN - 1);
          word_d   = is_word_i;
          signed_d = op_signed;
          rem_d    = op_rem;
          mul_d    = op_mul;
          sa_d     = sa;
          sb_d     = sb;
          acc_d    = '0;
          if (op_mul) begin
            opa_d = src_a_i;
            opb_d = src_b_i;
          end else if (op_div && !special) begin
            // Word dividends sit in the top half so the MSB is always consumed first.
            opa_d = is_word_i ? {prep_a[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : prep_a;
            opb_d = prep_b;
          end else begin
            pend_d = op_div ? special_res : '0;
          end
        end
      end
      StMul: begin
        if (opa_q[0]) acc_d = acc_q + opb_q;
        opb_d = opb_q << 1;
        opa_d = opa_q >> 1;
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      end
      StDiv: begin
        acc_d = div_fits ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0];
        opa_d = {opa_q[XLEN-2:0], div_fits};
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      end
      StFixup: pend_d = rem_q ? fix_b : fix_a;
      StDone:  if (!flush_i) result_d = pend_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      pend_q   <= '0;
      result_q <= '0;
      word_q   <= 1'b0;
      signed_q <= 1'b0;
      rem_q    <= 1'b0;
      mul_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      result_q <= result_d;
      word_q   <= word_d;
      signed_q <= signed_d;
      rem_q    <= rem_d;
      mul_q    <= mul_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
  import pipes_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  alufunc_t    func_i;
  logic        is_word_i;
  logic [63:0] src_a_i, src_b_i;
  logic        flush_i;
  logic        busy_o, resp_valid_o;
  logic [63:0] result_o;

  int n_checks = 0;
  int n_bad    = 0;
  logic [63:0] last_res = '0;

  muldiv_sequencer u_dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .func_i      (func_i),
    .is_word_i   (is_word_i),
    .src_a_i     (src_a_i),
    .src_b_i     (src_b_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .resp_valid_o(resp_valid_o),
    .result_o    (result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    alufunc_t    f;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic add_vec(input alufunc_t f, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat);
    vec_t v;
    v.f = f; v.w = w; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Latency counts cycles from the accept cycle; resp in the next cycle is latency 1.
  task automatic run_op(input string tag, input alufunc_t f, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    @(negedge clk_i);
    check_eq({tag, " ready"}, 64'(req_ready_o), 64'd1);
    func_i = f; is_word_i = w; src_a_i = a; src_b_i = b; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    lat = 1;
    while (!resp_valid_o && lat < 200) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " result"}, result_o, exp);
    last_res = exp;
    @(posedge clk_i); #1;
    check_eq({tag, " pulse end"}, 64'(resp_valid_o), 64'd0);
    check_eq({tag, " held"}, result_o, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset_i = 1'b1; req_valid_i = 1'b0; func_i = AluAdd; is_word_i = 1'b0;
    src_a_i = '0; src_b_i = '0; flush_i = 1'b0;

    #12;
    check_eq("rst busy", 64'(busy_o), 64'd0);
    check_eq("rst resp", 64'(resp_valid_o), 64'd0);
    check_eq("rst result", result_o, 64'd0);
    check_eq("rst ready", 64'(req_ready_o), 64'd1);
    @(negedge clk_i);
    reset_i = 1'b0;

    add_vec(AluMult, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    add_vec(AluDiv,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    add_vec(AluRem,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    add_vec(AluDivu, 1'b0, 64'd100, 64'd7, 64'd14, 66);
    add_vec(AluRemu, 1'b0, 64'd100, 64'd7, 64'd2, 66);
    add_vec(AluDivu, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    add_vec(AluRemu, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    add_vec(AluDiv,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 1);
    add_vec(AluRem,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    add_vec(AluMult, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    add_vec(AluDivu, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34);
    add_vec(AluDiv,  1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34);
    add_vec(AluRem,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    add_vec(AluDiv,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    add_vec(AluRem,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66);
    add_vec(AluMult, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 66);
    add_vec(AluDivu, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 66);
    add_vec(AluRemu, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 66);
    add_vec(AluAdd,  1'b0, 64'd1, 64'd2, 64'd0, 1);

    foreach (vecs[i]) begin
      run_op($sformatf("v%0d", i), vecs[i].f, vecs[i].w, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat);
    end

    // Flush ten cycles into a DIV
    @(negedge clk_i);
    func_i = AluDiv; is_word_i = 1'b0; src_a_i = 64'd1000; src_b_i = 64'd3;
    req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("div busy", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check_eq("flush ready", 64'(req_ready_o), 64'd1);
    check_eq("flush busy", 64'(busy_o), 64'd0);
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      if (resp_valid_o) seen++;
      @(posedge clk_i); #1;
    end
    check_eq("flush no resp", 64'(seen), 64'd0);
    check_eq("flush result kept", result_o, last_res);
    run_op("mul after flush", AluMult, 1'b0, 64'd3, 64'd4, 64'd12, 66);

    // Flush in DONE suppresses the pulse and leaves the result alone
    @(negedge clk_i);
    func_i = AluDivu; src_a_i = 64'd5; src_b_i = 64'd0; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    check_eq("done flush resp", 64'(resp_valid_o), 64'd0);
    check_eq("done flush result", result_o, 64'd12);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check_eq("done flush ready", 64'(req_ready_o), 64'd1);
    check_eq("done flush after", result_o, 64'd12);

    // Flush together with a request in idle drops the request
    @(negedge clk_i);
    func_i = AluMult; src_a_i = 64'd3; src_b_i = 64'd5; req_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; flush_i = 1'b0;
    check_eq("idle flush dropped", 64'(req_ready_o), 64'd1);
    seen = 0;
    for (int c = 0; c < 70; c++) begin
      if (resp_valid_o) seen++;
      @(posedge clk_i); #1;
    end
    check_eq("idle flush no resp", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of a MUL
    @(negedge clk_i);
    func_i = AluMult; src_a_i = 64'd9; src_b_i = 64'd9; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    check_eq("amid busy", 64'(busy_o), 64'd0);
    check_eq("amid resp", 64'(resp_valid_o), 64'd0);
    check_eq("amid result", result_o, 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check_eq("post rst ready", 64'(req_ready_o), 64'd1);
    run_op("mul after reset", AluMult, 1'b0, 64'd3, 64'd4, 64'd12, 66);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
